stream_mux_rr: RTL and testbench
================================

// Module: stream_mux_rr
// PURPOSE
//  Registered NUM_IN:1, WIDTH-bit stream multiplexer with valid/ready handshakes on every
//  input and on the output. Selection is either an external select (MODE_SEL) or internal
//  round-robin arbitration (MODE_RR). Generalises the combinational 2-bit 2:1 MUX_2bit.
//  Sits between producer channels and one shared downstream consumer.
// PARAMETERS
//  WIDTH   2  data bits per channel
//  NUM_IN  4  input channel count, >=2; need not be a power of two
//  MODE    0  0 = MODE_SEL (sel port picks the channel), 1 = MODE_RR (round-robin)
//  SELW    $clog2(NUM_IN)  derived local width of sel/out_chan; not overridable
// PORTS
//  clk        in   1             rising-edge clock, the only clock
//  rst_n      in   1             asynchronous, active-low reset
//  in_data    in   NUM_IN*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
//  in_valid   in   NUM_IN        per-channel valid
//  in_ready   out  NUM_IN        per-channel ready; combinational, one-hot or zero
//  sel        in   SELW          channel select, MODE_SEL only; ignored in MODE_RR
//  out_data   out  WIDTH         registered output data
//  out_valid  out  1             registered output valid
//  out_ready  in   1             downstream ready
//  out_chan   out  SELW          registered index of the channel that supplied out_data
// BEHAVIOUR
//  - Reset (async assert, sync release): out_valid=0, out_data=0, out_chan=0, rr_ptr=0.
//    Reset mid-transfer drops the held word; no input is acknowledged while rst_n=0.
//  - can_accept = !out_valid || out_ready (one-deep pipeline, full throughput).
//  - Grant g is combinational from current inputs. in_ready[g] = can_accept; every other
//    in_ready bit = 0. Transfer on channel g when in_valid[g] && in_ready[g].
//  - Transfer: out_data <= chan g data, out_chan <= g, out_valid <= 1 at the next edge.
//    Latency is 1 cycle from input handshake to out_valid.
//  - No transfer and out_ready=1: out_valid <= 0. out_ready=0: out_data/out_chan/out_valid
//    hold; out_data never changes while out_valid=1 && out_ready=0.
//  - MODE_SEL: g = sel. sel >= NUM_IN: no grant, in_ready = 0, no transfer. sel may change
//    any cycle; only the sel value on the handshake cycle matters.
//  - MODE_RR: g = first channel with in_valid=1, searching rr_ptr, rr_ptr+1, ... modulo
//    NUM_IN. No valid channel: no grant. After a transfer, rr_ptr <= (g+1) mod NUM_IN,
//    wrapping NUM_IN-1 -> 0 explicitly (non-power-of-two safe). No transfer: rr_ptr holds.
//  - Starvation bound (MODE_RR): a continuously valid channel is served within NUM_IN
//    transfers.
//  - Producers must hold in_valid/in_data until their handshake; the block does not check.
// STRUCTURE
//  - Package stream_mux_pkg: MODE_SEL=0, MODE_RR=1 localparams; wrap-increment function.
//  - Sub-module rr_arbiter (NUM_IN): req[NUM_IN], ptr[SELW] -> grant index + grant_valid;
//    rr_ptr register stays in stream_mux_rr. MODE_SEL bypasses the arbiter via generate.
//  - Top: grant mux, ready decode, output register, pointer update.
// TESTING
//  1 Reset: rst_n=0 with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0.
//    Release -> first word appears 1 cycle after the first handshake.
//  2 MODE_SEL, WIDTH=2, NUM_IN=4, out_ready=1: sweep sel=0..3 with in_data=8'b11_10_01_00,
//    all valid -> out_data = sel and out_chan = sel, each 1 cycle later (exhaustive 2-bit sweep).
//  3 MODE_SEL, NUM_IN=3, sel=3 -> in_ready=000, out_valid drops to 0 and stays 0.
//  4 MODE_RR, NUM_IN=3, all valid, out_ready=1 -> out_chan = 0,1,2,0,1 on consecutive
//    cycles; rr_ptr wraps 2->0.
//  5 Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> out_data/out_chan stable,
//    in_ready=0. Raise out_ready -> next word accepted the same cycle, no loss/duplication.
//  6 Reset asserted while out_valid=1 && out_ready=0 -> out_valid=0 immediately (async);
//    after release MODE_RR restarts at channel 0.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the registered round-robin stream multiplexer.
package stream_mux_pkg;

  localparam int unsigned MODE_SEL = 0;
  localparam int unsigned MODE_RR  = 1;

  // Increment an index modulo n with an explicit wrap, safe for non-power-of-two n.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    if (idx >= n - 1) begin
      return 0;
    end
    return idx + 1;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, modulo NUM_IN.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int unsigned NUM_IN = 4,
  localparam int unsigned SELW  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SELW-1:0]   ptr,
  output logic [SELW-1:0]   grant,
  output logic              grant_valid
);

  int unsigned idx;

  // Walk the channels starting at ptr and pick the first one that is requesting.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 32'(ptr);
    for (int i = 0; i < NUM_IN; i++) begin
      if (!grant_valid && req[idx]) begin
        grant       = SELW'(idx);
        grant_valid = 1'b1;
      end
      idx = wrap_inc(idx, NUM_IN);
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// Registered NUM_IN:1 stream multiplexer with valid/ready on every port.
// Channel choice comes from an external select or from round-robin arbitration.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int unsigned WIDTH  = 2,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned MODE   = 0,
  localparam int unsigned SELW  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SELW-1:0]         sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SELW-1:0]         out_chan
);

  logic [SELW-1:0]  grant;
  logic             grant_valid;
  logic             can_accept;
  logic             chan_valid;
  logic [WIDTH-1:0] chan_data;
  logic             xfer;

  if (MODE == MODE_RR) begin : g_rr
    logic [SELW-1:0] rr_ptr;
    logic            unused_sel;

    assign unused_sel = ^sel;

    rr_arbiter #(
      .NUM_IN (NUM_IN)
    ) u_arb (
      .req         (in_valid),
      .ptr         (rr_ptr),
      .grant       (grant),
      .grant_valid (grant_valid)
    );

    // Advance the pointer past the channel just served; hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rr_ptr <= '0;
      end else if (xfer) begin
        rr_ptr <= SELW'(wrap_inc(32'(grant), NUM_IN));
      end
    end
  end else begin : g_sel
    // Out-of-range select values grant nothing.
    assign grant       = sel;
    assign grant_valid = (32'(sel) < NUM_IN);
  end

  // One-deep pipeline: a new word may enter when the slot is empty or draining.
  assign can_accept = !out_valid || out_ready;

  // Decode the grant into ready bits and pick the granted channel's valid/data.
  // Ready is gated by reset so nothing is acknowledged while rst_n is low.
  always_comb begin
    in_ready   = '0;
    chan_valid = 1'b0;
    chan_data  = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (grant_valid && grant == SELW'(k)) begin
        in_ready[k] = can_accept && rst_n;
        chan_valid  = in_valid[k];
        chan_data   = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer = chan_valid && can_accept && rst_n && grant_valid;

  // Output register: load on transfer, drain on out_ready, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
    end else if (xfer) begin
      out_data  <= chan_data;
      out_chan  <= grant;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench: select mode with 4 and 3 channels, round-robin mode with 3 channels.
module tb_stream_mux_rr;

  logic clk;
  logic rst_n;

  // Select mode, 4 channels.
  logic [7:0] in_data4;
  logic [3:0] in_valid4;
  logic [3:0] in_ready4;
  logic [1:0] sel4;
  logic [1:0] out_data4;
  logic       out_valid4;
  logic       out_ready4;
  logic [1:0] out_chan4;

  // Select mode, 3 channels.
  logic [5:0] in_data3;
  logic [2:0] in_valid3;
  logic [2:0] in_ready3;
  logic [1:0] sel3;
  logic [1:0] out_data3;
  logic       out_valid3;
  logic       out_ready3;
  logic [1:0] out_chan3;

  // Round-robin mode, 3 channels.
  logic [5:0] in_datar;
  logic [2:0] in_validr;
  logic [2:0] in_readyr;
  logic [1:0] selr;
  logic [1:0] out_datar;
  logic       out_validr;
  logic       out_readyr;
  logic [1:0] out_chanr;

  int total;
  int fails;

  stream_mux_rr #(.WIDTH(2), .NUM_IN(4), .MODE(0)) u_sel4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data4),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .sel       (sel4),
    .out_data  (out_data4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .out_chan  (out_chan4)
  );

  stream_mux_rr #(.WIDTH(2), .NUM_IN(3), .MODE(0)) u_sel3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .sel       (sel3),
    .out_data  (out_data3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .out_chan  (out_chan3)
  );

  stream_mux_rr #(.WIDTH(2), .NUM_IN(3), .MODE(1)) u_rr3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_datar),
    .in_valid  (in_validr),
    .in_ready  (in_readyr),
    .sel       (selr),
    .out_data  (out_datar),
    .out_valid (out_validr),
    .out_ready (out_readyr),
    .out_chan  (out_chanr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total      = 0;
    fails      = 0;
    rst_n      = 1'b0;
    in_data4   = 8'b11_10_01_00;
    in_valid4  = 4'b1111;
    sel4       = 2'd0;
    out_ready4 = 1'b1;
    in_data3   = 6'b10_01_00;
    in_valid3  = 3'b111;
    sel3       = 2'd0;
    out_ready3 = 1'b1;
    in_datar   = 6'b10_01_00;
    in_validr  = 3'b111;
    selr       = 2'd0;
    out_readyr = 1'b1;

    // Reset with every channel valid: nothing acknowledged, outputs cleared.
    #2;
    chk("rst_valid4", 32'(out_valid4), 32'd0);
    chk("rst_data4", 32'(out_data4), 32'd0);
    chk("rst_ready4", 32'(in_ready4), 32'd0);
    chk("rst_readyr", 32'(in_readyr), 32'd0);
    step();
    step();
    chk("rst_hold_valid4", 32'(out_valid4), 32'd0);
    chk("rst_hold_validr", 32'(out_validr), 32'd0);

    // Release away from the edge; first handshake happens at the next edge.
    rst_n = 1'b1;
    #1;
    chk("rel_ready4", 32'(in_ready4), 32'b0001);
    chk("rel_readyr", 32'(in_readyr), 32'b001);
    chk("rel_valid4", 32'(out_valid4), 32'd0);

    // E1: sel4=0, sel3=0, round-robin grants channel 0.
    step();
    chk("e1_valid4", 32'(out_valid4), 32'd1);
    chk("e1_data4", 32'(out_data4), 32'd0);
    chk("e1_chan4", 32'(out_chan4), 32'd0);
    chk("e1_valid3", 32'(out_valid3), 32'd1);
    chk("e1_chanr", 32'(out_chanr), 32'd0);
    chk("e1_datar", 32'(out_datar), 32'd0);
    sel4 = 2'd1;
    sel3 = 2'd3;
    #1;
    chk("sel3_oob_ready", 32'(in_ready3), 32'b000);
    chk("sel4_1_ready", 32'(in_ready4), 32'b0010);

    // E2
    step();
    chk("e2_data4", 32'(out_data4), 32'd1);
    chk("e2_chan4", 32'(out_chan4), 32'd1);
    chk("e2_valid3", 32'(out_valid3), 32'd0);
    chk("e2_chanr", 32'(out_chanr), 32'd1);
    chk("e2_datar", 32'(out_datar), 32'd1);
    sel4 = 2'd2;

    // E3
    step();
    chk("e3_data4", 32'(out_data4), 32'd2);
    chk("e3_chan4", 32'(out_chan4), 32'd2);
    chk("e3_valid3", 32'(out_valid3), 32'd0);
    chk("e3_chanr", 32'(out_chanr), 32'd2);
    sel4 = 2'd3;

    // E4: round-robin wraps 2 -> 0.
    step();
    chk("e4_data4", 32'(out_data4), 32'd3);
    chk("e4_chan4", 32'(out_chan4), 32'd3);
    chk("e4_chanr", 32'(out_chanr), 32'd0);
    chk("e4_datar", 32'(out_datar), 32'd0);

    // E5
    step();
    chk("e5_chanr", 32'(out_chanr), 32'd1);
    chk("e5_valid3", 32'(out_valid3), 32'd0);
    chk("e5_ready3", 32'(in_ready3), 32'b000);

    // Backpressure on the 4-channel select instance holding chan 3.
    sel4       = 2'd1;
    out_ready4 = 1'b0;
    #1;
    chk("bp_ready_low", 32'(in_ready4), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(out_valid4), 32'd1);
      chk("bp_data", 32'(out_data4), 32'd3);
      chk("bp_chan", 32'(out_chan4), 32'd3);
      chk("bp_ready", 32'(in_ready4), 32'd0);
    end
    out_ready4 = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready4), 32'b0010);

    // E11: next word accepted on the release cycle.
    step();
    chk("bp_next_valid", 32'(out_valid4), 32'd1);
    chk("bp_next_data", 32'(out_data4), 32'd1);
    chk("bp_next_chan", 32'(out_chan4), 32'd1);
    in_valid4  = 4'b0000;
    out_readyr = 1'b0;

    // E12: no duplication on the 4-channel side; round-robin output stalls holding chan 1.
    step();
    chk("no_dup_valid4", 32'(out_valid4), 32'd0);
    chk("rr_stall_valid", 32'(out_validr), 32'd1);
    chk("rr_stall_chan", 32'(out_chanr), 32'd1);

    // Asynchronous reset mid-cycle while the round-robin word is held.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_validr", 32'(out_validr), 32'd0);
    chk("async_rst_datar", 32'(out_datar), 32'd0);
    chk("async_rst_chanr", 32'(out_chanr), 32'd0);
    step();
    chk("rst_held_validr", 32'(out_validr), 32'd0);
    rst_n      = 1'b1;
    out_readyr = 1'b1;

    // Pointer restarts at channel 0 after reset.
    step();
    chk("restart_validr", 32'(out_validr), 32'd1);
    chk("restart_chanr0", 32'(out_chanr), 32'd0);
    step();
    chk("restart_chanr1", 32'(out_chanr), 32'd1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
